// File: rtl/cla_pipelined_addsub_if.sv
// Operand/result handshake bundle for cla_pipelined_addsub.
// The master drives operands and out_ready; the slave (the adder) returns the result and flags.
interface cla_pipelined_addsub_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;
   logic             zero;

   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout, ovf, zero
   );

   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout, ovf, zero
   );
endinterface

// File: rtl/cla_pipelined_addsub.sv
// Two-stage pipelined carry-lookahead adder/subtractor built from 4-bit lookahead groups.
// Define CLA_SAT_EN to clamp signed-overflow results to the signed min/max value.
module cla_pipelined_addsub #(
   parameter int WIDTH = 16,
   parameter int GROUP = 4
) (
   input logic                   clk,
   input logic                   rst,
   cla_pipelined_addsub_if.slave bus
);
   localparam int NG = WIDTH / GROUP;

   if (GROUP != 4) begin : g_bad_group
      $error("cla_pipelined_addsub: GROUP must be 4 (got %0d)", GROUP);
   end
   if ((WIDTH % 4) != 0 || WIDTH < 4 || WIDTH > 64) begin : g_bad_width
      $error("cla_pipelined_addsub: WIDTH must be a multiple of 4 in 4..64 (got %0d)", WIDTH);
   end

   logic             advance;

   logic [WIDTH-1:0] b_eff;
   logic             c0_d;
   logic [WIDTH-1:0] p_d;
   logic [WIDTH-1:0] g_d;
   logic [NG-1:0]    gp_d;
   logic [NG-1:0]    gg_d;

   logic             s1_valid;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;
   logic             s1_c0;
   logic [WIDTH-1:0] s1_p;
   logic [WIDTH-1:0] s1_g;
   logic [NG-1:0]    s1_gp;
   logic [NG-1:0]    s1_gg;

   logic [NG:0]      gc;
   logic [WIDTH:0]   c;
   logic [WIDTH-1:0] raw_sum;
   logic             raw_ovf;
   logic [WIDTH-1:0] res_sum;

   logic             out_valid_q;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;
   logic             ovf_q;
   logic             zero_q;

   assign advance      = ~out_valid_q | bus.out_ready;
   assign bus.in_ready = advance;

   always_comb begin
      b_eff = bus.sub ? ~bus.b : bus.b;
      c0_d  = bus.sub | bus.cin;
      p_d   = bus.a | b_eff;
      g_d   = bus.a & b_eff;
      gp_d  = '0;
      gg_d  = '0;
      for (int k = 0; k < NG; k++) begin
         gp_d[k] = &p_d[GROUP*k +: GROUP];
         gg_d[k] = g_d[GROUP*k+3]
                 | (p_d[GROUP*k+3] & g_d[GROUP*k+2])
                 | (p_d[GROUP*k+3] & p_d[GROUP*k+2] & g_d[GROUP*k+1])
                 | (p_d[GROUP*k+3] & p_d[GROUP*k+2] & p_d[GROUP*k+1] & g_d[GROUP*k]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
      end else if (advance) begin
         s1_valid <= bus.in_valid;
      end
   end

   // Operand registers need no reset: s1_valid qualifies them.
   always_ff @(posedge clk) begin
      if (advance && bus.in_valid) begin
         s1_a  <= bus.a;
         s1_b  <= b_eff;
         s1_c0 <= c0_d;
         s1_p  <= p_d;
         s1_g  <= g_d;
         s1_gp <= gp_d;
         s1_gg <= gg_d;
      end
   end

   // Group carries come from the second-level lookahead; each group's entry carry
   // is taken from it rather than from the ripple of the previous group.
   always_comb begin
      gc[0] = s1_c0;
      for (int k = 0; k < NG; k++) begin
         gc[k+1] = s1_gg[k] | (s1_gp[k] & gc[k]);
      end
      c = '0;
      for (int k = 0; k < NG; k++) begin
         c[GROUP*k] = gc[k];
         for (int i = 0; i < GROUP - 1; i++) begin
            c[GROUP*k+i+1] = s1_g[GROUP*k+i] | (s1_p[GROUP*k+i] & c[GROUP*k+i]);
         end
      end
      c[WIDTH] = gc[NG];
      raw_sum  = s1_a ^ s1_b ^ c[WIDTH-1:0];
      raw_ovf  = c[WIDTH] ^ c[WIDTH-1];
   end

   // The top p/g bit of each group is consumed only through GP/GG in stage 1.
   logic unused_pg_top;
   always_comb begin
      unused_pg_top = 1'b0;
      for (int k = 0; k < NG; k++) begin
         unused_pg_top = unused_pg_top ^ s1_p[GROUP*k+3] ^ s1_g[GROUP*k+3];
      end
   end

`ifdef CLA_SAT_EN
   always_comb begin
      res_sum = raw_sum;
      if (raw_ovf) begin
         res_sum = s1_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                 : {1'b0, {(WIDTH-1){1'b1}}};
      end
   end
`else
   assign res_sum = raw_sum;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
         zero_q      <= 1'b0;
      end else if (advance) begin
         out_valid_q <= s1_valid;
         if (s1_valid) begin
            sum_q  <= res_sum;
            cout_q <= c[WIDTH];
            ovf_q  <= raw_ovf;
            zero_q <= ~|res_sum;
         end
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.sum       = sum_q;
   assign bus.cout      = cout_q;
   assign bus.ovf       = ovf_q;
   assign bus.zero      = zero_q;
endmodule
